dafx_amplitude_monitor: RTL and testbench
=========================================

# dafx_amplitude_monitor

Tracks the running minimum and maximum sample values of the ADC input stream and the DAC output stream, and raises sticky clip interrupts. It sits beside the audio datapath, directly upstream of the DAFX AXI register bank. It produces the `sr_cir_*_amplitude` status registers and the two IRQ lines, and consumes `cmd_clear_adc_amplitude`, `cmd_clear_irq_0` and `cmd_clear_irq_1` from that bank.

## Interface
- `AUDIO_WIDTH_P`, default 24: sample width, two's complement signed.
- `CLIP_LEVEL_P`, default 8388352 (2^23-256): magnitude at or beyond which a sample counts as clipping. Valid range 1 to 2^(W-1)-1.
- `CLIP_COUNT_P`, default 4: consecutive clipping samples needed to raise an IRQ. Must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `adc_left`, `adc_right`  in  W  ADC sample pair.
- `adc_valid`  in  1  one-cycle strobe; the pair is valid this cycle.
- `dac_left`, `dac_right`  in  W  DAC sample pair (mixer output).
- `dac_valid`  in  1  one-cycle strobe for the DAC pair.
- `cmd_clear_adc_amplitude`  in  1  pulse; empties both ADC and DAC min/max trackers.
- `cmd_clear_irq_0`, `cmd_clear_irq_1`  in  1  pulse; clears `irq_0` or `irq_1` and its run counter.
- `sr_cir_min_adc_amplitude`, `sr_cir_max_adc_amplitude`  out  W  ADC extremes.
- `sr_cir_min_dac_amplitude`, `sr_cir_max_dac_amplitude`  out  W  DAC extremes.
- `irq_0`  out  1  sticky ADC clip interrupt.
- `irq_1`  out  1  sticky DAC clip interrupt.

## Operation
- There are two identical tracker instances: ADC and DAC. Each has an `empty` flag, registered `min` and `max` values, a clip run counter, and an IRQ flag.
- Tracker states:
  - EMPTY: `min` and `max` outputs read 0.
  - TRACKING: holds the extremes.
- EMPTY → TRACKING on the first valid pair. The first pair loads `min` = smaller of L,R and `max` = larger of L,R.
- In TRACKING, each valid pair updates:
  - `min` ← signed min(`min`, L, R)
  - `max` ← signed max(`max`, L, R)
- All comparisons are signed at W bits. No widening, no absolute value on the min/max path.
- Any state → EMPTY when `cmd_clear_adc_amplitude` is asserted.
- Clear and valid in the same cycle: the clear applies first. The tracker loads that cycle's pair as its first sample and ends in TRACKING.
- Clip test per pair: the pair clips if L or R satisfies `sample` ≥ `CLIP_LEVEL_P` or `sample` ≤ −`CLIP_LEVEL_P`.
  - Both bounds are inclusive.
  - The most negative code (−2^(W-1)) always clips.
- Run counter, updated on a valid pair:
  - Clipping pair: increment, saturating at `CLIP_COUNT_P`.
  - Non-clipping pair: reset to 0.
  - The counter holds between valid strobes; gaps do not break a run.
- IRQ set: the IRQ flag goes to 1 on the valid pair that brings the counter to `CLIP_COUNT_P`. It stays at 1, and further clipping does not re-trigger it.
- `cmd_clear_irq_n` clears the IRQ flag and resets the counter to 0.
  - If a valid pair arrives in the same cycle, the clear wins and that pair is ignored for clip counting. It is still used for min/max.
  - A new IRQ then requires `CLIP_COUNT_P` fresh consecutive clipping pairs.
- `cmd_clear_adc_amplitude` does not affect the IRQs or the counters.
- The ADC and DAC streams are fully independent. Simultaneous `adc_valid` and `dac_valid` are both processed in the same cycle.

## Timing
- Reset values:
  - All `sr_*` outputs: 0.
  - Trackers: EMPTY.
  - Counters: 0.
  - `irq_0`, `irq_1`: 0.
- Min/max latency: outputs reflect a valid pair on the cycle after the strobe (one register stage).
- IRQ latency: `irq_n` rises on the cycle after the valid strobe that completes the run. It falls on the cycle after `cmd_clear_irq_n`.
- Clear latency: after `cmd_clear_adc_amplitude`, the outputs read 0 on the next cycle unless a sample was loaded in the same cycle.
- Back-to-back valids are supported every cycle, with no stall and no ready signal.
- Reset asserted mid-run: everything returns to reset values asynchronously. The first valid after release starts from EMPTY.
- All outputs are registered, with no combinational input-to-output paths.

## Test plan
All scenarios use W=24, CLIP_LEVEL_P=1000, CLIP_COUNT_P=3.
- Reset, then ADC pair (L=−5, R=12) → next cycle min=−5, max=12. Then pair (3, 40) → min=−5, max=40. DAC outputs remain 0.
- In TRACKING, assert `cmd_clear_adc_amplitude` alone → next cycle all four outputs read 0. Clear together with ADC pair (7, 7) → min=max=7.
- ADC pairs (1000, 0), (0, −1000), (−1200, 5) → `irq_0` rises one cycle after the third strobe. `irq_1` stays 0.
- ADC pairs (1000, 0), (999, 0), (1000, 0), (1000, 0) → no IRQ, because the counter resets at the 999 pair. One more clipping pair → `irq_0`=1.
- With `irq_0`=1, pulse `cmd_clear_irq_0` in the same cycle as a clipping pair → `irq_0`=0 next cycle. It then takes exactly 3 new clipping pairs to re-raise, and min/max did include the discarded pair.
- Simultaneous ADC pair (−8388608, 0) and DAC pair (2, 3) every cycle for 3 cycles → `irq_0`=1, `irq_1`=0, ADC min=−8388608, DAC min=2, DAC max=3. Assert `rst_n` low mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/dafx_amplitude_monitor.sv
// dafx_amplitude_monitor
//
// Tracks the running signed minimum and maximum of the ADC and DAC sample
// pair streams. Raises a sticky clip interrupt per stream once a run of
// consecutive clipping pairs reaches CLIP_COUNT_P.
//
// Ports
//   clk, rst_n                      system clock, async active-low reset
//   adc_left/adc_right/adc_valid    ADC sample pair and one-cycle strobe
//   dac_left/dac_right/dac_valid    DAC sample pair and one-cycle strobe
//   cmd_clear_adc_amplitude         pulse: empties both min/max trackers
//   cmd_clear_irq_0/_1              pulse: clears irq_0/irq_1 and run counter
//   sr_cir_{min,max}_adc_amplitude  ADC extremes (0 while empty)
//   sr_cir_{min,max}_dac_amplitude  DAC extremes (0 while empty)
//   irq_0, irq_1                    sticky ADC / DAC clip interrupts
//
// Handshake: *_valid is a one-cycle strobe with no ready. Every strobed
// pair is consumed in that cycle, back-to-back strobes included.
// All outputs come straight from registers.

module dafx_amplitude_monitor #(
  parameter int AUDIO_WIDTH_P = 24,
  parameter int CLIP_LEVEL_P  = 8388352,
  parameter int CLIP_COUNT_P  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_P-1:0] adc_left,
  input  logic [AUDIO_WIDTH_P-1:0] adc_right,
  input  logic                     adc_valid,
  input  logic [AUDIO_WIDTH_P-1:0] dac_left,
  input  logic [AUDIO_WIDTH_P-1:0] dac_right,
  input  logic                     dac_valid,
  input  logic                     cmd_clear_adc_amplitude,
  input  logic                     cmd_clear_irq_0,
  input  logic                     cmd_clear_irq_1,
  output logic [AUDIO_WIDTH_P-1:0] sr_cir_min_adc_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_cir_max_adc_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_cir_min_dac_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_cir_max_dac_amplitude,
  output logic                     irq_0,
  output logic                     irq_1
);

  localparam int W  = AUDIO_WIDTH_P;
  localparam int CW = $clog2(CLIP_COUNT_P + 1);

  localparam logic signed [W-1:0] CLIP_HI = W'(CLIP_LEVEL_P);
  localparam logic signed [W-1:0] CLIP_LO = W'(-CLIP_LEVEL_P);
  localparam logic [CW-1:0]       CNT_MAX = CW'(CLIP_COUNT_P);

  typedef enum logic {
    EMPTY    = 1'b0,
    TRACKING = 1'b1
  } tracker_state_t;

  // Tracker 0 watches the ADC stream, tracker 1 the DAC stream.
  for (genvar g = 0; g < 2; g++) begin : trk
    logic signed [W-1:0] smp_l, smp_r;
    logic                smp_valid;
    logic                clr_irq;

    logic signed [W-1:0] pair_min, pair_max;
    logic                clip;

    tracker_state_t      state;
    logic signed [W-1:0] min_q, max_q;
    logic [CW-1:0]       cnt;
    logic                irq_q;

    assign smp_l     = (g == 0) ? adc_left  : dac_left;
    assign smp_r     = (g == 0) ? adc_right : dac_right;
    assign smp_valid = (g == 0) ? adc_valid : dac_valid;
    assign clr_irq   = (g == 0) ? cmd_clear_irq_0 : cmd_clear_irq_1;

    always_comb begin
      pair_min = (smp_l < smp_r) ? smp_l : smp_r;
      pair_max = (smp_l < smp_r) ? smp_r : smp_l;
      // The most negative code is always <= CLIP_LO, so it always clips.
      clip = (smp_l >= CLIP_HI) || (smp_l <= CLIP_LO) ||
             (smp_r >= CLIP_HI) || (smp_r <= CLIP_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= EMPTY;
        min_q <= '0;
        max_q <= '0;
        cnt   <= '0;
        irq_q <= 1'b0;
      end else begin
        // Min/max path. A clear that coincides with a valid pair behaves
        // as "clear, then load this pair as the first sample".
        if (smp_valid) begin
          if (state == EMPTY || cmd_clear_adc_amplitude) begin
            min_q <= pair_min;
            max_q <= pair_max;
          end else begin
            if (pair_min < min_q) min_q <= pair_min;
            if (pair_max > max_q) max_q <= pair_max;
          end
          state <= TRACKING;
        end else if (cmd_clear_adc_amplitude) begin
          min_q <= '0;
          max_q <= '0;
          state <= EMPTY;
        end

        // Clip run path. An IRQ clear discards the coincident pair for
        // counting so a new IRQ needs a fully fresh run.
        if (clr_irq) begin
          cnt   <= '0;
          irq_q <= 1'b0;
        end else if (smp_valid) begin
          if (clip) begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (cnt >= CNT_MAX - CW'(1)) irq_q <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
      end
    end
  end

  assign sr_cir_min_adc_amplitude = trk[0].min_q;
  assign sr_cir_max_adc_amplitude = trk[0].max_q;
  assign sr_cir_min_dac_amplitude = trk[1].min_q;
  assign sr_cir_max_dac_amplitude = trk[1].max_q;
  assign irq_0                    = trk[0].irq_q;
  assign irq_1                    = trk[1].irq_q;

endmodule

// File: tb/tb_dafx_amplitude_monitor.sv
// Testbench for dafx_amplitude_monitor (W=24, CLIP_LEVEL_P=1000,
// CLIP_COUNT_P=3). A reference model keeps the list of samples seen since
// the last amplitude clear and the list of clip flags seen since the last
// IRQ clear, and derives the outputs from those lists. A negedge process
// compares every output against it each cycle; directed literal checks
// pin the model to hand-computed values.

module tb_dafx_amplitude_monitor;

  localparam int W  = 24;
  localparam int CL = 1000;
  localparam int CC = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] adc_left = '0, adc_right = '0, dac_left = '0, dac_right = '0;
  logic         adc_valid = 1'b0, dac_valid = 1'b0;
  logic         cmd_clear_adc_amplitude = 1'b0;
  logic         cmd_clear_irq_0 = 1'b0, cmd_clear_irq_1 = 1'b0;
  logic [W-1:0] min_adc, max_adc, min_dac, max_dac;
  logic         irq_0, irq_1;

  dafx_amplitude_monitor #(
    .AUDIO_WIDTH_P(W), .CLIP_LEVEL_P(CL), .CLIP_COUNT_P(CC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .adc_left(adc_left), .adc_right(adc_right), .adc_valid(adc_valid),
    .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
    .cmd_clear_adc_amplitude(cmd_clear_adc_amplitude),
    .cmd_clear_irq_0(cmd_clear_irq_0), .cmd_clear_irq_1(cmd_clear_irq_1),
    .sr_cir_min_adc_amplitude(min_adc), .sr_cir_max_adc_amplitude(max_adc),
    .sr_cir_min_dac_amplitude(min_dac), .sr_cir_max_dac_amplitude(max_dac),
    .irq_0(irq_0), .irq_1(irq_1)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic check_en = 1'b0;

  int adc_samp[$];
  int dac_samp[$];
  bit adc_clip[$];
  bit dac_clip[$];
  bit m_irq0 = 1'b0, m_irq1 = 1'b0;

  function automatic int qmin(input int q[$]);
    int m;
    if (q.size() == 0) return 0;
    m = q[0];
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic int qmax(input int q[$]);
    int m;
    if (q.size() == 0) return 0;
    m = q[0];
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic bit is_clip(input int s);
    return (s >= CL) || (s <= -CL);
  endfunction

  // True when the last CC entries of the flag list are all clipping.
  function automatic bit run_done(input bit q[$]);
    if (q.size() < CC) return 1'b0;
    for (int i = q.size() - CC; i < q.size(); i++) if (!q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    adc_samp.delete(); dac_samp.delete();
    adc_clip.delete(); dac_clip.delete();
    m_irq0 = 1'b0; m_irq1 = 1'b0;
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic model_step();
    if (cmd_clear_adc_amplitude) begin
      adc_samp.delete();
      dac_samp.delete();
    end
    if (adc_valid) begin
      adc_samp.push_back(sx(adc_left));
      adc_samp.push_back(sx(adc_right));
    end
    if (dac_valid) begin
      dac_samp.push_back(sx(dac_left));
      dac_samp.push_back(sx(dac_right));
    end
    if (cmd_clear_irq_0) begin
      adc_clip.delete(); m_irq0 = 1'b0;
    end else if (adc_valid) begin
      adc_clip.push_back(is_clip(sx(adc_left)) || is_clip(sx(adc_right)));
      if (run_done(adc_clip)) m_irq0 = 1'b1;
    end
    if (cmd_clear_irq_1) begin
      dac_clip.delete(); m_irq1 = 1'b0;
    end else if (dac_valid) begin
      dac_clip.push_back(is_clip(sx(dac_left)) || is_clip(sx(dac_right)));
      if (run_done(dac_clip)) m_irq1 = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("cyc_min_adc", min_adc, W'(qmin(adc_samp)));
      chk("cyc_max_adc", max_adc, W'(qmax(adc_samp)));
      chk("cyc_min_dac", min_dac, W'(qmin(dac_samp)));
      chk("cyc_max_dac", max_dac, W'(qmax(dac_samp)));
      chk("cyc_irq_0", W'(irq_0), W'(m_irq0));
      chk("cyc_irq_1", W'(irq_1), W'(m_irq1));
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle of inputs, update the model at the edge, then idle
  // the inputs 1 time unit later.
  task automatic cyc(input int al, input int ar, input bit av,
                     input int dl, input int dr, input bit dv,
                     input bit ca, input bit c0, input bit c1);
    @(negedge clk);
    adc_left = W'(al); adc_right = W'(ar); adc_valid = av;
    dac_left = W'(dl); dac_right = W'(dr); dac_valid = dv;
    cmd_clear_adc_amplitude = ca;
    cmd_clear_irq_0 = c0; cmd_clear_irq_1 = c1;
    @(posedge clk);
    model_step();
    #1;
    adc_valid = 1'b0; dac_valid = 1'b0;
    cmd_clear_adc_amplitude = 1'b0;
    cmd_clear_irq_0 = 1'b0; cmd_clear_irq_1 = 1'b0;
  endtask

  task automatic adc(input int l, input int r);
    cyc(l, r, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic dac(input int l, input int r);
    cyc(0, 0, 1'b0, l, r, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_min_adc"}, min_adc, '0);
    chk({tag, "_max_adc"}, max_adc, '0);
    chk({tag, "_min_dac"}, min_dac, '0);
    chk({tag, "_max_dac"}, max_dac, '0);
    chk({tag, "_irq_0"}, W'(irq_0), '0);
    chk({tag, "_irq_1"}, W'(irq_1), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Basic tracking
    adc(-5, 12);
    chk("first_min", min_adc, W'(-5));
    chk("first_max", max_adc, W'(12));
    adc(3, 40);
    chk("second_min", min_adc, W'(-5));
    chk("second_max", max_adc, W'(40));
    chk("dac_untouched", max_dac, '0);

    // Amplitude clear alone, then clear with a pair
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_min", min_adc, '0);
    chk("clr_max", max_adc, '0);
    cyc(7, 7, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_load_min", min_adc, W'(7));
    chk("clr_load_max", max_adc, W'(7));

    // Three clipping pairs, inclusive bounds
    adc(1000, 0);
    adc(0, -1000);
    chk("run2_no_irq", W'(irq_0), '0);
    adc(-1200, 5);
    chk("run3_irq0", W'(irq_0), W'(1));
    chk("run3_irq1", W'(irq_1), '0);

    // Broken run
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("irq0_cleared", W'(irq_0), '0);
    adc(1000, 0);
    adc(999, 0);
    adc(1000, 0);
    adc(1000, 0);
    chk("broken_run", W'(irq_0), '0);
    adc(1000, 0);
    chk("rerun_irq0", W'(irq_0), W'(1));
    adc(2000, 0);
    chk("irq0_sticky", W'(irq_0), W'(1));

    // IRQ clear together with a clipping pair
    cyc(2000, -3000, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_wins_irq0", W'(irq_0), '0);
    chk("discard_min", min_adc, W'(-3000));
    chk("discard_max", max_adc, W'(2000));
    adc(1500, 0);
    adc(0, 1500);
    chk("fresh2_no_irq", W'(irq_0), '0);
    adc(-1500, 0);
    chk("fresh3_irq0", W'(irq_0), W'(1));

    // DAC run with gaps between strobes
    dac(1000, 0);
    idle();
    dac(-1000, 0);
    idle();
    idle();
    chk("dac_gap_no_irq", W'(irq_1), '0);
    dac(0, 1500);
    chk("dac_gap_irq1", W'(irq_1), W'(1));
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("irq1_cleared", W'(irq_1), '0);
    chk("irq0_kept", W'(irq_0), W'(1));

    // Simultaneous streams with the most negative code
    cyc(0, 0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(-8388608, 0, 1'b1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sim_irq0", W'(irq_0), W'(1));
    chk("sim_irq1", W'(irq_1), '0);
    chk("sim_min_adc", min_adc, 24'h800000);
    chk("sim_max_adc", max_adc, '0);
    chk("sim_min_dac", min_dac, W'(2));
    chk("sim_max_dac", max_dac, W'(3));

    // Asynchronous reset mid-stream
    @(negedge clk);
    adc_left = W'(-8388608); adc_right = '0; adc_valid = 1'b1;
    dac_left = W'(2); dac_right = W'(3); dac_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_rst");
    adc_valid = 1'b0; dac_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // First pair after reset starts from empty
    adc(50, 60);
    chk("post_rst_min", min_adc, W'(50));
    chk("post_rst_max", max_adc, W'(60));
    idle();
    idle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
